// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM stage, two-entry skid buffer (head H, skid S) with
// branch resolution and a decode-stage forwarding tap driven from the head.
module ex_mem_pipe #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic [REGW-1:0] rd_addr,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            branch_ne,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] branch_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_result,
    output logic [REGW-1:0] out_rd_addr,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [XLEN-1:0] out_store_data,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_pc,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
);
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] target;
        logic [REGW-1:0] rd;
        logic            zero;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            branch_ne;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t r_state, w_next;
    entry_t r_h, r_s, w_in;
    logic   w_accept, w_drain, w_load_h, w_load_s;

    // Both handshake flags decode the state register only, so in_ready has no path from out_ready.
    assign out_valid = r_state != EMPTY;
    assign in_ready  = r_state != FULL;
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    always_comb begin
        w_in            = '0;
        w_in.result     = alu_result;
        w_in.store_data = store_data;
        w_in.target     = branch_target;
        w_in.rd         = rd_addr;
        w_in.zero       = alu_zero;
        w_in.reg_write  = reg_write && (rd_addr != '0);
        w_in.mem_read   = mem_read;
        w_in.mem_write  = mem_write;
        w_in.branch     = branch;
        w_in.branch_ne  = branch_ne;
    end

    always_comb begin
        w_next   = r_state;
        w_load_h = 1'b0;
        w_load_s = 1'b0;
        unique case (r_state)
            EMPTY: begin
                w_next   = w_accept ? ONE : EMPTY;
                w_load_h = w_accept;
            end
            ONE: begin
                w_next   = (w_accept && !w_drain) ? FULL : (w_drain && !w_accept) ? EMPTY : ONE;
                w_load_h = w_accept && w_drain;
                w_load_s = w_accept && !w_drain;
            end
            FULL: begin
                w_next   = w_drain ? ONE : FULL;
                w_load_h = w_drain;
            end
            default: w_next = EMPTY;
        endcase
        if (flush) begin
            w_next   = EMPTY;
            w_load_h = 1'b0;
            w_load_s = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_h     <= '0;
            r_s     <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_h) r_h <= (r_state == FULL) ? r_s : w_in;
            if (w_load_s) r_s <= w_in;
        end
    end

    assign out_alu_result = r_h.result;
    assign out_rd_addr    = r_h.rd;
    assign out_reg_write  = r_h.reg_write;
    assign out_mem_read   = r_h.mem_read;
    assign out_mem_write  = r_h.mem_write;
    assign out_store_data = r_h.store_data;
    assign branch_taken   = out_valid && r_h.branch && (r_h.zero ^ r_h.branch_ne);
    assign branch_pc      = r_h.target;
    // Load data only exists after MEM, so loads are never offered for forwarding.
    assign fwd_valid      = out_valid && r_h.reg_write && !r_h.mem_read;
    assign fwd_rd         = r_h.rd;
    assign fwd_data       = r_h.result;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: table-driven directed vectors plus hand sequences for
// reset, flush and reset/flush priority on ex_mem_pipe.
module tb_ex_mem_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, alu_zero, reg_write, mem_read, mem_write;
    logic        branch, branch_ne, flush, out_valid, out_ready, out_reg_write;
    logic        out_mem_read, out_mem_write, branch_taken, fwd_valid;
    logic [63:0] alu_result, store_data, branch_target, out_alu_result, out_store_data;
    logic [63:0] branch_pc, fwd_data;
    logic [4:0]  rd_addr, out_rd_addr, fwd_rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.XLEN(64), .REGW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .branch_ne(branch_ne), .store_data(store_data),
        .branch_target(branch_target), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu_result(out_alu_result),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_store_data(out_store_data), .branch_taken(branch_taken),
        .branch_pc(branch_pc), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data)
    );

    typedef struct {
        logic        iv, ordy;
        logic [63:0] res;
        logic        z;
        logic [4:0]  rd;
        logic        rw, mr, br, bne;
        logic [63:0] tgt;
        logic        e_ov, e_ir;
        logic [63:0] e_res;
        logic        e_bt, e_fv, e_rw;
        logic [4:0]  e_rd;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic iv, logic ordy, logic [63:0] res, logic z, logic [4:0] rd,
                                logic rw, logic mr, logic br, logic bne, logic [63:0] tgt,
                                logic e_ov, logic e_ir, logic [63:0] e_res, logic e_bt,
                                logic e_fv, logic e_rw, logic [4:0] e_rd, logic [63:0] e_pc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.res = res; v.z = z; v.rd = rd; v.rw = rw; v.mr = mr;
        v.br = br; v.bne = bne; v.tgt = tgt; v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res;
        v.e_bt = e_bt; v.e_fv = e_fv; v.e_rw = e_rw; v.e_rd = e_rd; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; alu_result = 0; alu_zero = 0; rd_addr = 0; reg_write = 0;
        mem_read = 0; mem_write = 0; branch = 0; branch_ne = 0; store_data = 0;
        branch_target = 0; flush = 0; out_ready = 0; reset = 0;
    endtask

    task automatic push(input logic iv, input logic ordy, input logic [63:0] res);
        @(negedge clk);
        in_valid = iv; out_ready = ordy; alu_result = res; store_data = res ^ 64'hFF;
        rd_addr = 5'd9; reg_write = 1; mem_read = 0; branch = 0; alu_zero = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        // reset held two cycles with an offered entry
        @(negedge clk);
        reset = 1; in_valid = 1; alu_result = 64'h55; rd_addr = 5'd1; reg_write = 1;
        branch = 1; alu_zero = 1; branch_target = 64'h99; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_alu_result", out_alu_result, 0);
        chk("rst branch_taken", branch_taken, 0);
        chk("rst fwd_valid", fwd_valid, 0);
        chk("rst branch_pc", branch_pc, 0);
        chk("rst out_rd_addr", out_rd_addr, 0);
        chk("rst out_store_data", out_store_data, 0);
        chk("rst out_reg_write", out_reg_write, 0);
        @(negedge clk);
        idle_inputs();

        vecs[0]  = mk(1,1,64'h5,   0,5'd1,1,0,0,0,64'h0,    1,1,64'h5,   0,1,1,5'd1,64'h0);
        vecs[1]  = mk(1,1,64'h7,   0,5'd2,1,0,0,0,64'h0,    1,1,64'h7,   0,1,1,5'd2,64'h0);
        vecs[2]  = mk(1,1,64'h9,   0,5'd3,1,0,0,0,64'h0,    1,1,64'h9,   0,1,1,5'd3,64'h0);
        vecs[3]  = mk(0,1,64'h0,   0,5'd0,0,0,0,0,64'h0,    0,1,64'h9,   0,0,1,5'd3,64'h0);
        vecs[4]  = mk(1,0,64'h10,  0,5'd5,1,0,0,0,64'h0,    1,1,64'h10,  0,1,1,5'd5,64'h0);
        vecs[5]  = mk(1,0,64'h20,  0,5'd6,1,0,0,0,64'h0,    1,0,64'h10,  0,1,1,5'd5,64'h0);
        vecs[6]  = mk(1,0,64'h30,  0,5'd7,1,0,0,0,64'h0,    1,0,64'h10,  0,1,1,5'd5,64'h0);
        vecs[7]  = mk(1,1,64'h30,  0,5'd7,1,0,0,0,64'h0,    1,1,64'h20,  0,1,1,5'd6,64'h0);
        vecs[8]  = mk(1,1,64'h30,  0,5'd7,1,0,0,0,64'h0,    1,1,64'h30,  0,1,1,5'd7,64'h0);
        vecs[9]  = mk(0,1,64'h0,   0,5'd0,0,0,0,0,64'h0,    0,1,64'h30,  0,0,1,5'd7,64'h0);
        vecs[10] = mk(1,1,64'h11,  1,5'd0,0,0,1,0,64'h1000, 1,1,64'h11,  1,0,0,5'd0,64'h1000);
        vecs[11] = mk(1,1,64'h12,  1,5'd0,0,0,1,1,64'h2000, 1,1,64'h12,  0,0,0,5'd0,64'h2000);
        vecs[12] = mk(1,1,64'h13,  0,5'd0,0,0,1,1,64'h3000, 1,1,64'h13,  1,0,0,5'd0,64'h3000);
        vecs[13] = mk(1,1,64'h14,  0,5'd0,0,0,1,0,64'h4000, 1,1,64'h14,  0,0,0,5'd0,64'h4000);
        vecs[14] = mk(1,1,64'h15,  1,5'd0,0,0,0,0,64'h5000, 1,1,64'h15,  0,0,0,5'd0,64'h5000);
        vecs[15] = mk(1,1,64'hDEAD,0,5'd3,1,0,0,0,64'h0,    1,1,64'hDEAD,0,1,1,5'd3,64'h0);
        vecs[16] = mk(1,1,64'hBEEF,0,5'd0,1,0,0,0,64'h0,    1,1,64'hBEEF,0,0,0,5'd0,64'h0);
        vecs[17] = mk(1,1,64'h44,  0,5'd4,1,1,0,0,64'h0,    1,1,64'h44,  0,0,1,5'd4,64'h0);
        vecs[18] = mk(0,1,64'h0,   0,5'd0,0,0,0,0,64'h0,    0,1,64'h44,  0,0,1,5'd4,64'h0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            in_valid = vecs[i].iv; out_ready = vecs[i].ordy; alu_result = vecs[i].res;
            store_data = vecs[i].res ^ 64'hFF; alu_zero = vecs[i].z; rd_addr = vecs[i].rd;
            reg_write = vecs[i].rw; mem_read = vecs[i].mr; branch = vecs[i].br;
            branch_ne = vecs[i].bne; branch_target = vecs[i].tgt;
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("v%0d out_alu_result", i), out_alu_result, vecs[i].e_res);
            chk($sformatf("v%0d out_store_data", i), out_store_data, vecs[i].e_res ^ 64'hFF);
            chk($sformatf("v%0d branch_taken", i), branch_taken, vecs[i].e_bt);
            chk($sformatf("v%0d fwd_valid", i), fwd_valid, vecs[i].e_fv);
            chk($sformatf("v%0d out_reg_write", i), out_reg_write, vecs[i].e_rw);
            chk($sformatf("v%0d fwd_rd", i), fwd_rd, vecs[i].e_rd);
            chk($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].e_res);
            chk($sformatf("v%0d branch_pc", i), branch_pc, vecs[i].e_pc);
        end

        // flush in FULL with an offered entry: nothing survives, incoming dropped
        push(1, 0, 64'hA1);
        push(1, 0, 64'hA2);
        chk("full in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1; in_valid = 1; alu_result = 64'hF0;
        @(posedge clk); #1;
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        @(negedge clk);
        flush = 0; in_valid = 0; out_ready = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post-flush out_valid", out_valid, 0);
        end
        // flush while ONE with in_ready high: the offered entry is dropped too
        push(1, 0, 64'hB1);
        @(negedge clk);
        flush = 1; in_valid = 1; alu_result = 64'hB2;
        @(posedge clk); #1;
        chk("flush1 out_valid", out_valid, 0);
        @(negedge clk);
        flush = 0; in_valid = 0;
        @(posedge clk); #1;
        chk("flush1 stays empty", out_valid, 0);
        push(1, 1, 64'h77);
        chk("post-flush accept valid", out_valid, 1);
        chk("post-flush accept data", out_alu_result, 64'h77);

        // reset and flush together from FULL
        push(1, 0, 64'hC1);
        push(1, 0, 64'hC2);
        @(negedge clk);
        reset = 1; flush = 1; in_valid = 1;
        @(posedge clk); #1;
        chk("rstflush out_valid", out_valid, 0);
        chk("rstflush in_ready", in_ready, 1);
        chk("rstflush out_alu_result", out_alu_result, 0);
        chk("rstflush fwd_valid", fwd_valid, 0);
        @(negedge clk);
        reset = 0; flush = 0; in_valid = 0;
        @(posedge clk); #1;
        chk("after rst empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Execute-to-memory pipeline stage that sits directly downstream of the ALU (add/sub/slt/sltu units). It captures each ALU result, its zero flag and the instruction's control bits into a two-entry skid buffer with a valid/ready handshake. From the head entry it drives the memory stage, the branch-taken decision (beq/bne from the zero flag) and a forwarding tap for the decode stage. It supports stall and flush without dropping or duplicating instructions.

Parameters:
XLEN, 64, datapath width of ALU result, store data and branch target
REGW, 5, register index width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream (ALU) entry valid
in_ready  output  1  stage can accept an entry this cycle
alu_result  input  XLEN  ALU output rd value
alu_zero  input  1  ALU zero flag
rd_addr  input  REGW  destination register index
reg_write  input  1  instruction writes rd
mem_read  input  1  load
mem_write  input  1  store
branch  input  1  conditional branch
branch_ne  input  1  1 = bne, 0 = beq (valid only with branch)
store_data  input  XLEN  rs2 value for stores
branch_target  input  XLEN  precomputed PC target
flush  input  1  discard all held entries
out_valid  output  1  head entry valid
out_ready  input  1  memory stage consumes head
out_alu_result  output  XLEN  head ALU result (memory address or rd value)
out_rd_addr  output  REGW  head rd index
out_reg_write  output  1  head write enable (already x0-masked)
out_mem_read  output  1  head load
out_mem_write  output  1  head store
out_store_data  output  XLEN  head store data
branch_taken  output  1  head is a resolved taken branch
branch_pc  output  XLEN  head branch target
fwd_valid  output  1  forwarding tap valid
fwd_rd  output  REGW  forwarding register index
fwd_data  output  XLEN  forwarding value

Behaviour:
- Storage: head register H and skid register S, each with its own valid bit. States: EMPTY (neither valid), ONE (H only), FULL (H and S).
- in_ready = !S.valid, driven from a register with no combinational path from out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept -> H loaded, ONE. Latency is 1 cycle from accept to out_valid.
- ONE: accept & drain -> H replaced, ONE. Accept only -> S loaded, FULL. Drain only -> EMPTY. Neither -> hold.
- FULL: drain -> H <= S, S cleared, ONE. Otherwise hold. No accept is possible because in_ready = 0.
- Order is strictly FIFO. Each accepted entry appears exactly once on out_* with out_valid = 1.
- x0 rule: entries with rd_addr == 0 are stored with reg_write forced to 0.
- branch_taken = out_valid & H.branch & (H.zero ^ H.branch_ne). It is combinational from H and independent of out_ready.
- branch_pc = H.branch_target.
- fwd_valid = out_valid & out_reg_write & !out_mem_read. fwd_rd and fwd_data come from H. Load data is not available here, so loads never forward.
- flush: both valid bits clear on the next edge and in_ready = 1 the next cycle. flush has priority over a simultaneous accept: that entry is dropped and in_ready still reads 1 that cycle.
- Data fields of invalid entries hold their last value, except that reset zeroes them.
- reset (synchronous, in any state, including mid-stall or FULL): all valid bits = 0, all data registers = 0. After the edge: out_valid = 0, branch_taken = 0, fwd_valid = 0, in_ready = 1.
- reset dominates flush. The cycle after reset deasserts behaves exactly as EMPTY.
- No arithmetic is performed. Widths pass through unmodified.

Test Plan:
- Reset: assert reset 2 cycles with in_valid = 1 -> out_valid = 0, in_ready = 1, all out_* = 0, branch_taken = 0.
- Streaming: out_ready = 1, push alu_result = 5, 7, 9 on consecutive cycles -> out_alu_result = 5, 7, 9 one cycle later each, in_ready stays 1.
- Backpressure: out_ready = 0, push A = 0x10, B = 0x20, C = 0x30 -> in_ready drops after B, C held upstream. Then out_ready = 1 -> outputs 0x10, 0x20, 0x30 in order, no loss or duplication.
- Branch: beq with alu_zero = 1 -> branch_taken = 1, branch_pc = target. bne with alu_zero = 1 -> 0. beq with zero = 0 -> 0. Non-branch with zero = 1 -> 0.
- Forwarding and x0: reg_write with rd = 3, result 0xDEAD -> fwd_valid = 1, fwd_rd = 3. rd = 0 -> out_reg_write = 0, fwd_valid = 0. Load to rd = 4 -> fwd_valid = 0.
- Flush/reset priority: in FULL assert flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, incoming entry never emitted. flush and reset together -> reset values.
